// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT_IF = 2'b01,
    ST_GRANT_DM = 2'b10
  } state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_port_arbiter_mux2t1_32.sv
// Plain 2:1 word select; in1 is chosen when sel_i is high.
module MUX2T1_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic         sel_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and data access (DM), with a per-access watchdog.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | no access in flight; arbitrate eligible requests
// ST_GRANT_IF | fetch access on the port, waiting for mem_ready
// ST_GRANT_DM | data access on the port, waiting for mem_ready
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              busy
);

  // Last watchdog count before an unanswered grant is abandoned.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [7:0]        wd_cnt_q;
  logic              mem_sel_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_ack_q, dm_ack_q, err_q;

  logic              if_elig, dm_elig;
  logic              done, tmo, start, next_sel;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // A requester being acked this cycle must re-request on a later cycle.
  assign if_elig  = if_req & ~if_ack_q;
  assign dm_elig  = dm_req & ~dm_ack_q;
  assign start    = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign next_sel = (state_d == ST_GRANT_DM);

  MUX2T1_32 #(.W(ADDR_W)) u_addr_mux (
    .in0_i (if_addr),
    .in1_i (dm_addr),
    .sel_i (next_sel),
    .out_o (addr_mux)
  );

  MUX2T1_32 #(.W(DATA_W)) u_wdata_mux (
    .in0_i ('0),
    .in1_i (dm_wdata),
    .sel_i (next_sel),
    .out_o (wdata_mux)
  );

  // Next-state: round-robin pick in IDLE, completion or watchdog exit in a grant.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_elig && dm_elig)
          state_d = (last_grant_q == SEL_DM) ? ST_GRANT_IF : ST_GRANT_DM;
        else if (if_elig)
          state_d = ST_GRANT_IF;
        else if (dm_elig)
          state_d = ST_GRANT_DM;
      end
      ST_GRANT_IF, ST_GRANT_DM: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request, watchdog and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SEL_DM;
      wd_cnt_q     <= '0;
      mem_sel_q    <= SEL_IF;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= (done | tmo) && (state_q == ST_GRANT_IF);
      dm_ack_q <= (done | tmo) && (state_q == ST_GRANT_DM);
      err_q    <= tmo;

      if (start) begin
        mem_sel_q    <= next_sel;
        mem_addr_q   <= addr_mux;
        mem_wdata_q  <= wdata_mux;
        mem_we_q     <= next_sel & dm_we;
        last_grant_q <= next_sel;
      end else if (done | tmo) begin
        mem_we_q <= 1'b0;
      end

      if ((state_q != ST_IDLE) && !(done | tmo)) begin
        if (wd_cnt_q != 8'hFF) wd_cnt_q <= wd_cnt_q + 8'd1;
      end else begin
        wd_cnt_q <= '0;
      end

      if (done && (state_q == ST_GRANT_IF)) if_rdata_q <= mem_rdata;
      if (done && (state_q == ST_GRANT_DM) && !mem_we_q) dm_rdata_q <= mem_rdata;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = busy;
  assign mem_sel   = mem_sel_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter, built with TIMEOUT=4.
module tb_mem_port_arbiter;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  typedef struct packed {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_ack;
    logic        dm_ack;
    logic        err;
    logic        busy;
    logic        mem_en;
    logic        mem_sel;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_sel, mem_en, mem_we, err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .busy(busy)
  );

  function automatic in_t In(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                             logic [31:0] da, logic [31:0] dd, logic rdy, logic [31:0] rd);
    return '{r, ir, ia, dr, dw, da, dd, rdy, rd};
  endfunction

  function automatic out_t Ot(logic ia, logic da, logic er, logic bs, logic en, logic sl,
                              logic we, logic [31:0] ad, logic [31:0] wd,
                              logic [31:0] ir, logic [31:0] dr);
    return '{ia, da, er, bs, en, sl, we, ad, wd, ir, dr};
  endfunction

  task automatic add(in_t i, out_t o);
    vecs.push_back('{i, o});
  endtask

  task automatic apply(in_t i);
    rst_n     = i.rst_n;
    if_req    = i.if_req;
    if_addr   = i.if_addr;
    dm_req    = i.dm_req;
    dm_we     = i.dm_we;
    dm_addr   = i.dm_addr;
    dm_wdata  = i.dm_wdata;
    mem_ready = i.mem_ready;
    mem_rdata = i.mem_rdata;
  endtask

  task automatic chk(string name, out_t e);
    out_t a;
    a = {if_ack, dm_ack, err, busy, mem_en, mem_sel, mem_we, mem_addr, mem_wdata,
         if_rdata, dm_rdata};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got ack=%b/%b err=%b busy=%b en=%b sel=%b we=%b addr=%h wd=%h ird=%h drd=%h ; exp ack=%b/%b err=%b busy=%b en=%b sel=%b we=%b addr=%h wd=%h ird=%h drd=%h",
               name, a.if_ack, a.dm_ack, a.err, a.busy, a.mem_en, a.mem_sel, a.mem_we,
               a.mem_addr, a.mem_wdata, a.if_rdata, a.dm_rdata,
               e.if_ack, e.dm_ack, e.err, e.busy, e.mem_en, e.mem_sel, e.mem_we,
               e.mem_addr, e.mem_wdata, e.if_rdata, e.dm_rdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle;
    idle = In(Y, N, 0, N, N, 0, 0, N, 0);
    apply(In(N, N, 0, N, N, 0, 0, N, 0));

    // reset state
    add(In(N, N, 0, N, N, 0, 0, N, 0), Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    add(idle,                          Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    // single IF read
    add(In(Y, Y, 32'h40, N, N, 0, 0, N, 0),           Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    add(In(Y, Y, 32'h40, N, N, 0, 0, Y, 32'h24020005), Ot(N,N,N,Y,Y,N,N, 32'h40, 0, 0, 0));
    add(idle, Ot(Y,N,N,N,N,N,N, 32'h40, 0, 32'h24020005, 0));
    add(idle, Ot(N,N,N,N,N,N,N, 32'h40, 0, 32'h24020005, 0));
    // async reset clears everything, including read data
    add(In(N, N, 0, N, N, 0, 0, N, 0), Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    add(idle,                          Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    // simultaneous requests alternate IF, DM, IF, DM
    add(In(Y, Y, 32'h100, Y, Y, 32'h200, 32'hA5A50001, N, 0), Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    add(In(Y, Y, 32'h100, Y, Y, 32'h200, 32'hA5A50001, Y, 32'h11111111), Ot(N,N,N,Y,Y,N,N, 32'h100, 0, 0, 0));
    add(In(Y, Y, 32'h100, Y, Y, 32'h200, 32'hA5A50001, N, 0), Ot(Y,N,N,N,N,N,N, 32'h100, 0, 32'h11111111, 0));
    add(In(Y, Y, 32'h100, Y, Y, 32'h200, 32'hA5A50001, Y, 32'h22222222), Ot(N,N,N,Y,Y,Y,Y, 32'h200, 32'hA5A50001, 32'h11111111, 0));
    add(In(Y, Y, 32'h100, Y, N, 32'h204, 32'hA5A50001, N, 0), Ot(N,Y,N,N,N,Y,N, 32'h200, 32'hA5A50001, 32'h11111111, 0));
    add(In(Y, Y, 32'h100, Y, N, 32'h204, 32'hA5A50001, Y, 32'h33333333), Ot(N,N,N,Y,Y,N,N, 32'h100, 0, 32'h11111111, 0));
    add(In(Y, Y, 32'h100, Y, N, 32'h204, 32'hA5A50001, N, 0), Ot(Y,N,N,N,N,N,N, 32'h100, 0, 32'h33333333, 0));
    add(In(Y, Y, 32'h100, Y, N, 32'h204, 32'hA5A50001, Y, 32'h44444444), Ot(N,N,N,Y,Y,Y,N, 32'h204, 32'hA5A50001, 32'h33333333, 0));
    add(idle, Ot(N,Y,N,N,N,Y,N, 32'h204, 32'hA5A50001, 32'h33333333, 32'h44444444));
    add(idle, Ot(N,N,N,N,N,Y,N, 32'h204, 32'hA5A50001, 32'h33333333, 32'h44444444));
    // DM write, mem_ready in the last watchdog cycle wins over the timeout
    add(In(Y, N, 0, Y, Y, 32'h10000004, 32'hDEADBEEF, N, 0), Ot(N,N,N,N,N,Y,N, 32'h204, 32'hA5A50001, 32'h33333333, 32'h44444444));
    for (int k = 0; k < 3; k++)
      add(In(Y, N, 0, Y, Y, 32'h10000004, 32'hDEADBEEF, N, 0), Ot(N,N,N,Y,Y,Y,Y, 32'h10000004, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    add(In(Y, N, 0, Y, Y, 32'h10000004, 32'hDEADBEEF, Y, 32'h55555555), Ot(N,N,N,Y,Y,Y,Y, 32'h10000004, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    add(idle, Ot(N,Y,N,N,N,Y,N, 32'h10000004, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    add(idle, Ot(N,N,N,N,N,Y,N, 32'h10000004, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    // DM read that never completes: 4 grant cycles, then ack+err; IF follows
    add(In(Y, N, 0, Y, N, 32'h300, 32'hDEADBEEF, N, 0), Ot(N,N,N,N,N,Y,N, 32'h10000004, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    for (int k = 0; k < 4; k++)
      add(In(Y, N, 0, Y, N, 32'h300, 32'hDEADBEEF, N, 0), Ot(N,N,N,Y,Y,Y,N, 32'h300, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    add(In(Y, Y, 32'h80, N, N, 0, 0, N, 0), Ot(N,Y,Y,N,N,Y,N, 32'h300, 32'hDEADBEEF, 32'h33333333, 32'h44444444));
    add(In(Y, Y, 32'h80, N, N, 0, 0, Y, 32'h66666666), Ot(N,N,N,Y,Y,N,N, 32'h80, 0, 32'h33333333, 32'h44444444));
    add(idle, Ot(Y,N,N,N,N,N,N, 32'h80, 0, 32'h66666666, 32'h44444444));
    // mem_ready while idle is ignored
    add(In(Y, N, 0, N, N, 0, 0, Y, 32'h77777777), Ot(N,N,N,N,N,N,N, 32'h80, 0, 32'h66666666, 32'h44444444));
    add(idle, Ot(N,N,N,N,N,N,N, 32'h80, 0, 32'h66666666, 32'h44444444));
    // IF request held through ack: one ack every 3 cycles
    add(In(Y, Y, 32'hC0, N, N, 0, 0, N, 0), Ot(N,N,N,N,N,N,N, 32'h80, 0, 32'h66666666, 32'h44444444));
    add(In(Y, Y, 32'hC0, N, N, 0, 0, Y, 32'h1), Ot(N,N,N,Y,Y,N,N, 32'hC0, 0, 32'h66666666, 32'h44444444));
    add(In(Y, Y, 32'hC0, N, N, 0, 0, N, 0), Ot(Y,N,N,N,N,N,N, 32'hC0, 0, 32'h1, 32'h44444444));
    add(In(Y, Y, 32'hC0, N, N, 0, 0, N, 0), Ot(N,N,N,N,N,N,N, 32'hC0, 0, 32'h1, 32'h44444444));
    add(In(Y, Y, 32'hC0, N, N, 0, 0, Y, 32'h2), Ot(N,N,N,Y,Y,N,N, 32'hC0, 0, 32'h1, 32'h44444444));
    add(In(Y, Y, 32'hC0, N, N, 0, 0, N, 0), Ot(Y,N,N,N,N,N,N, 32'hC0, 0, 32'h2, 32'h44444444));
    add(idle, Ot(N,N,N,N,N,N,N, 32'hC0, 0, 32'h2, 32'h44444444));

    tick();
    tick();
    foreach (vecs[k]) begin
      apply(vecs[k].i);
      #1;
      chk($sformatf("vec%0d", k), vecs[k].o);
      tick();
    end

    // async reset in the second grant cycle of an IF access
    apply(In(Y, Y, 32'hE0, N, N, 0, 0, N, 0));
    tick();
    chk("rst_grant_c1", Ot(N,N,N,Y,Y,N,N, 32'hE0, 0, 32'h2, 32'h44444444));
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    tick();
    apply(In(Y, Y, 32'hF0, Y, Y, 32'h400, 32'h12345678, N, 0));
    #1;
    chk("rst_release_no_ack", Ot(N,N,N,N,N,N,N, 0, 0, 0, 0));
    tick();
    chk("rst_tie_to_if", Ot(N,N,N,Y,Y,N,N, 32'hF0, 0, 0, 0));
    apply(In(Y, Y, 32'hF0, Y, Y, 32'h400, 32'h12345678, Y, 32'hCAFE0001));
    tick();
    chk("rst_if_ack", Ot(Y,N,N,N,N,N,N, 32'hF0, 0, 32'hCAFE0001, 0));
    apply(In(Y, N, 0, Y, Y, 32'h400, 32'h12345678, N, 0));
    tick();
    chk("rst_dm_grant", Ot(N,N,N,Y,Y,Y,Y, 32'h400, 32'h12345678, 32'hCAFE0001, 0));
    apply(In(Y, N, 0, Y, Y, 32'h400, 32'h12345678, Y, 32'h0BAD0BAD));
    tick();
    chk("rst_dm_ack", Ot(N,Y,N,N,N,Y,N, 32'h400, 32'h12345678, 32'hCAFE0001, 0));
    apply(idle);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
